// File: rtl/mult_div_pkg.sv
// Shared definitions for the shift-add multiplier and the shift-subtract divider.
package mult_div_pkg;

    localparam int unsigned DEFAULT_N = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/div_datapath.sv
// Restoring-division datapath: partial remainder A, quotient/dividend shift
// register Q and divisor D. One compare-subtract step per step strobe.
module div_datapath
    import mult_div_pkg::*;
#(
    parameter int unsigned N = DEFAULT_N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         load_dvz,
    input  logic         step,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder
);

    // A only ever holds a value below D once loaded, so N bits suffice;
    // the extra compare bit lives in the shifted trial value t.
    logic [N-1:0] a_q, a_d;
    logic [N-1:0] q_q, q_d;
    logic [N-1:0] d_q, d_d;
    logic [N:0]   t;
    logic         ge;

    // Next-state for load, divide-by-zero preset and one restoring step.
    always_comb begin
        t   = {a_q, q_q[N-1]};
        ge  = (t >= {1'b0, d_q});
        a_d = a_q;
        q_d = q_q;
        d_d = d_q;
        if (load) begin
            a_d = '0;
            q_d = dividend;
            d_d = divisor;
        end else if (load_dvz) begin
            a_d = dividend;
            q_d = '1;
            d_d = divisor;
        end else if (step) begin
            a_d = ge ? N'(t - {1'b0, d_q}) : t[N-1:0];
            q_d = {q_q[N-2:0], ge};
        end
    end

    // Datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;
            q_q <= '0;
            d_q <= '0;
        end else begin
            a_q <= a_d;
            q_q <= q_d;
            d_q <= d_d;
        end
    end

    assign quotient  = q_q;
    assign remainder = a_q;

endmodule

// File: rtl/shift_sub_divider.sv
// Unsigned restoring divider, one quotient bit per clock, with the
// st/idle/done handshake shared with the shift-add multiplier.
module shift_sub_divider
    import mult_div_pkg::*;
#(
    parameter int unsigned N = DEFAULT_N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         st,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         idle,
    output logic         done,
    output logic         dvz,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder
);

    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dvz_q, dvz_d;
    logic          load, load_dvz, step;

    // Control FSM next state, bit counter and datapath strobes.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dvz_d    = dvz_q;
        load     = 1'b0;
        load_dvz = 1'b0;
        step     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (st) begin
                    if (divisor == '0) begin
                        load_dvz = 1'b1;
                        dvz_d    = 1'b1;
                        state_d  = S_DONE;
                    end else begin
                        load    = 1'b1;
                        cnt_d   = '0;
                        dvz_d   = 1'b0;
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                step  = 1'b1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(N - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, counter and divide-by-zero flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            dvz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvz_q   <= dvz_d;
        end
    end

    div_datapath #(
        .N(N)
    ) u_datapath (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .load_dvz  (load_dvz),
        .step      (step),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder)
    );

    assign idle = (state_q == S_IDLE);
    assign done = (state_q == S_DONE);
    assign dvz  = dvz_q;

endmodule

// File: tb/tb_shift_sub_divider.sv
// Directed and exhaustive bench for shift_sub_divider (N=4) with a result scoreboard.
module tb_shift_sub_divider;

    localparam int unsigned N = 4;

    typedef struct {
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         dvz;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         st;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         idle;
    logic         done;
    logic         dvz;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    logic prev_done = 1'b0;

    shift_sub_divider #(
        .N(N)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .st        (st),
        .dividend  (dividend),
        .divisor   (divisor),
        .idle      (idle),
        .done      (done),
        .dvz       (dvz),
        .quotient  (quotient),
        .remainder (remainder)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [N-1:0] dd, input logic [N-1:0] dv);
        exp_t e;
        if (dv == 0) begin
            e.q = '1;
            e.r = dd;
            e.dvz = 1'b1;
        end else begin
            e.q = dd / dv;
            e.r = dd % dv;
            e.dvz = 1'b0;
        end
        return e;
    endfunction

    // Scoreboard monitor: every done pulse pops and compares one expected result.
    always @(negedge clk) begin
        if (done) begin
            exp_t e;
            check("done_width", {31'd0, prev_done}, 32'd0);
            if (sb.size() == 0) begin
                check("sb_underflow", sb.size(), 1);
            end else begin
                e = sb.pop_front();
                check("quotient", {28'd0, quotient}, {28'd0, e.q});
                check("remainder", {28'd0, remainder}, {28'd0, e.r});
                check("dvz", {31'd0, dvz}, {31'd0, e.dvz});
            end
        end
        prev_done = done;
    end

    task automatic wait_idle();
        @(negedge clk);
        for (int i = 0; i < 20 && idle !== 1'b1; i++) @(negedge clk);
        check("idle_wait", {31'd0, idle}, 32'd1);
    endtask

    task automatic do_op(input logic [N-1:0] dd, input logic [N-1:0] dv);
        int k;
        bit seen;
        wait_idle();
        dividend = dd;
        divisor  = dv;
        st       = 1'b1;
        sb.push_back(model(dd, dv));
        @(posedge clk);
        #1;
        st       = 1'b0;
        dividend = N'($urandom);
        divisor  = N'($urandom);
        k = 0;
        seen = 0;
        for (int i = 1; i <= int'(N) + 3 && !seen; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                k = i;
            end else begin
                check("idle_in_run", {31'd0, idle}, 32'd0);
            end
        end
        check("latency", k, (dv == 0) ? 1 : N + 1);
        if (dv != 0) begin
            check("identity", quotient * dv + remainder, {28'd0, dd});
            check("rem_lt_div", {31'd0, remainder < dv}, 32'd1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int dt[$];
        rst_n    = 1'b0;
        st       = 1'b0;
        dividend = '0;
        divisor  = '0;
        #3;
        check("rst_idle", {31'd0, idle}, 32'd1);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_dvz", {31'd0, dvz}, 32'd0);
        check("rst_quotient", {28'd0, quotient}, 32'd0);
        check("rst_remainder", {28'd0, remainder}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic operations, divide-by-zero and recovery.
        do_op(4'd13, 4'd3);
        do_op(4'd15, 4'd1);
        do_op(4'd5, 4'd7);
        do_op(4'd9, 4'd0);
        do_op(4'd6, 4'd2);

        // st held high for 20 edges: accepted at edges 1, 7, 13, 19.
        wait_idle();
        dividend = 4'd14;
        divisor  = 4'd4;
        st       = 1'b1;
        for (int i = 0; i < 4; i++) sb.push_back(model(4'd14, 4'd4));
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk);
            #1;
            if (c == 20) st = 1'b0;
            @(negedge clk);
            if (done) dt.push_back(c);
        end
        check("held_done_count", dt.size(), 4);
        for (int i = 1; i < dt.size(); i++) begin
            check("held_spacing", dt[i] - dt[i-1], N + 2);
        end
        check("held_first_done", (dt.size() > 0) ? dt[0] : 0, 5);

        // Asynchronous reset in the second RUN cycle of 15/4.
        wait_idle();
        dividend = 4'd15;
        divisor  = 4'd4;
        st       = 1'b1;
        @(posedge clk);
        #1;
        st = 1'b0;
        @(posedge clk);
        #2;
        check("pre_rst_idle", {31'd0, idle}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("arst_idle", {31'd0, idle}, 32'd1);
        check("arst_done", {31'd0, done}, 32'd0);
        check("arst_dvz", {31'd0, dvz}, 32'd0);
        check("arst_quotient", {28'd0, quotient}, 32'd0);
        check("arst_remainder", {28'd0, remainder}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(4'd11, 4'd5);

        // Exhaustive sweep of nonzero divisors.
        for (int a = 0; a < 16; a++) begin
            for (int b = 1; b < 16; b++) begin
                do_op(N'(a), N'(b));
            end
        end

        repeat (8) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
